ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width of ALU result, store data and PC+4.
REQ-002 SHALL have parameter REG_FILE_ADDRESS_WIDTH, default 5, destination register index width.
REQ-003 SHALL have parameter ADDR_CTRL_WIDTH, default 3, load/store addressing-control width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port flush  in  1  discard all held entries.
REQ-008 SHALL have port ValidE  in  1  execute stage offers an entry.
REQ-009 SHALL have port ReadyE  out  1  stage can accept an entry (registered).
REQ-010 SHALL have ports RegWriteE 1, ResultSrcE 2, MemWriteE 1, ALUResultE DATA_WIDTH, WriteDataE DATA_WIDTH, RdE REG_FILE_ADDRESS_WIDTH, PCPlus4E DATA_WIDTH and AddressingControlE ADDR_CTRL_WIDTH, all inputs carrying the offered payload.
REQ-011 SHALL have port ValidM  out  1  memory-stage entry present.
REQ-012 SHALL have port ReadyM  in  1  memory stage consumes the entry this cycle.
REQ-013 SHALL have ports RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M and AddressingControlM, all outputs matching their E widths.

Function
REQ-014 SHALL hold two entries: main (drives M outputs) and skid; each has a valid bit.
REQ-015 SHALL accept on ValidE && ReadyE; SHALL transfer out on ValidM && ReadyM.
REQ-016 SHALL load an accepted entry into main when main is empty or transferring out this cycle; ValidM SHALL then assert the next cycle (latency 1).
REQ-017 SHALL load an accepted entry into skid when main is full and not transferring out.
REQ-018 SHALL, on transfer out with skid valid, move skid to main in the same edge; a simultaneous accept in that cycle is impossible (ReadyE low).
REQ-019 SHALL drive ReadyE = NOT skid_valid, registered, with no combinational path from ReadyM.
REQ-020 SHALL preserve entry order; no entry SHALL be duplicated or dropped except by flush/rst.
REQ-021 SHALL drive ValidM = main_valid.
REQ-022 SHALL force RegWriteM and MemWriteM to 0 whenever ValidM is 0; data fields are don't-care when invalid.
REQ-023 SHALL, on flush, clear both valid bits at the edge; flush has priority over simultaneous accept (the accepted entry is discarded).
REQ-024 SHALL keep M outputs stable while ValidM && !ReadyM.

Reset
REQ-025 SHALL, on rst at a rising edge, clear main_valid and skid_valid, set ReadyE = 1, and zero all M payload registers.
REQ-026 SHALL give rst priority over flush and accept; rst mid-stall discards both entries.

Configuration
REQ-027 SHALL, with macro EX_MEM_STAGE_PERF_EN defined, add outputs StallCount (32 bits; increments when ValidM && !ReadyM) and FlushCount (16 bits; increments when flush is asserted with at least one valid entry).
REQ-028 Both counters SHALL saturate at their maximum, clear on rst, and be unaffected by flush clearing.
REQ-029 SHALL, without EX_MEM_STAGE_PERF_EN, have neither the counter ports nor their logic.

Verification
REQ-030 Streaming: ReadyM=1, ValidE=1 for 4 cycles with ALUResultE=1,2,3,4 -> ValidM high cycles 1-4, ALUResultM 1,2,3,4, ReadyE constantly 1.
REQ-031 Backpressure: with main holding 0xA and ReadyM=0, accept 0xB -> ReadyE=0 the next cycle; raise ReadyM -> M outputs 0xA then 0xB; ReadyE returns to 1.
REQ-032 Flush collision: main and skid full, flush=1 with ValidE=1 and RegWriteE=1 -> next cycle ValidM=0, RegWriteM=0, MemWriteM=0, ReadyE=1.
REQ-033 Reset mid-stall: both entries full, rst=1 for one cycle -> ValidM=0, ALUResultM=0, ReadyE=1; a new entry 0x5 offered afterwards appears at M one cycle later.
REQ-034 Perf (macro defined): hold ReadyM=0 for 10 cycles with ValidM=1, then one flush -> StallCount=10, FlushCount=1; preload StallCount near max -> it holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with two-entry skid buffer (optional perf counters: EX_MEM_STAGE_PERF_EN)
module ex_mem_stage #(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5,
    parameter int ADDR_CTRL_WIDTH        = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              ValidE,
    output logic                              ReadyE,
    input  logic                              RegWriteE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              MemWriteE,
    input  logic [DATA_WIDTH-1:0]             ALUResultE,
    input  logic [DATA_WIDTH-1:0]             WriteDataE,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
    input  logic [DATA_WIDTH-1:0]             PCPlus4E,
    input  logic [ADDR_CTRL_WIDTH-1:0]        AddressingControlE,
`ifdef EX_MEM_STAGE_PERF_EN
    output logic [31:0]                       StallCount,
    output logic [15:0]                       FlushCount,
`endif
    output logic                              ValidM,
    input  logic                              ReadyM,
    output logic                              RegWriteM,
    output logic [1:0]                        ResultSrcM,
    output logic                              MemWriteM,
    output logic [DATA_WIDTH-1:0]             ALUResultM,
    output logic [DATA_WIDTH-1:0]             WriteDataM,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
    output logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic [ADDR_CTRL_WIDTH-1:0]        AddressingControlM
);

    localparam int PW = 4 + 3 * DATA_WIDTH + REG_FILE_ADDRESS_WIDTH + ADDR_CTRL_WIDTH;

    logic [PW-1:0] in_w;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          accept_w;
    logic          xfer_w;
    logic          reg_write_raw;
    logic          mem_write_raw;

    assign in_w = {RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE,
                   RdE, PCPlus4E, AddressingControlE};

    // ReadyE comes straight from the skid valid flop, so ReadyM never reaches it
    assign ReadyE   = ~skid_valid_q;
    assign accept_w = ValidE & ReadyE;
    assign xfer_w   = main_valid_q & ReadyM;

    // Next-state: refill main from skid first, otherwise from the input; overflow goes to skid
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (xfer_w) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_w) begin
                main_d       = in_w;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_w) begin
            if (!main_valid_q) begin
                main_d       = in_w;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_w;
                skid_valid_d = 1'b1;
            end
        end
    end

    // Entry registers; reset clears valids and zeroes payload
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign {reg_write_raw, ResultSrcM, mem_write_raw, ALUResultM, WriteDataM,
            RdM, PCPlus4M, AddressingControlM} = main_q;

    // Side-effecting controls are masked so a bubble can never write
    assign ValidM    = main_valid_q;
    assign RegWriteM = reg_write_raw & main_valid_q;
    assign MemWriteM = mem_write_raw & main_valid_q;

`ifdef EX_MEM_STAGE_PERF_EN
    logic [31:0] stall_count_q;
    logic [15:0] flush_count_q;

    // Saturating count of cycles the memory stage refuses a valid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (main_valid_q && !ReadyM && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    // Saturating count of flushes that actually discarded something
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count_q <= '0;
        end else if (flush && (main_valid_q || skid_valid_q) && (flush_count_q != 16'hFFFF)) begin
            flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int AW = 3;
    localparam int PW = 4 + 3 * DW + RW + AW;

    logic          clk = 1'b0;
    logic          rst, flush, ValidE, ReadyE, ReadyM, ValidM;
    logic          RegWriteE, MemWriteE, RegWriteM, MemWriteM;
    logic [1:0]    ResultSrcE, ResultSrcM;
    logic [DW-1:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [RW-1:0] RdE, RdM;
    logic [AW-1:0] AddressingControlE, AddressingControlM;
`ifdef EX_MEM_STAGE_PERF_EN
    logic [31:0]   StallCount;
    logic [15:0]   FlushCount;
`endif

    int checks   = 0;
    int failures = 0;
    logic [PW-1:0] sb[$];
    logic [PW-1:0] in_vec, out_vec, exp_vec, held_vec;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_WIDTH(DW), .REG_FILE_ADDRESS_WIDTH(RW), .ADDR_CTRL_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ValidE(ValidE), .ReadyE(ReadyE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
        .PCPlus4E(PCPlus4E), .AddressingControlE(AddressingControlE),
`ifdef EX_MEM_STAGE_PERF_EN
        .StallCount(StallCount), .FlushCount(FlushCount),
`endif
        .ValidM(ValidM), .ReadyM(ReadyM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .AddressingControlM(AddressingControlM)
    );

    assign in_vec  = {RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE, RdE, PCPlus4E, AddressingControlE};
    assign out_vec = {RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M, AddressingControlM};

    // Scoreboard: inputs are stable at the falling edge, so handshakes seen here happen at the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (ValidM && ReadyM) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h, expected no entry", out_vec);
                end else begin
                    exp_vec = sb.pop_front();
                    if (out_vec !== exp_vec) begin
                        failures++;
                        $display("FAIL sb_payload: got %h, expected %h", out_vec, exp_vec);
                    end
                end
            end
            if (flush) sb.delete();
            else if (ValidE && ReadyE) sb.push_back(in_vec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input logic [DW-1:0] alu);
        RegWriteE          = 1'($urandom);
        ResultSrcE         = 2'($urandom);
        MemWriteE          = 1'($urandom);
        ALUResultE         = alu;
        WriteDataE         = $urandom;
        RdE                = RW'($urandom);
        PCPlus4E           = $urandom;
        AddressingControlE = AW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ValidE = 1'b0; ReadyM = 1'b0;
        set_payload(32'h0);
        tick(); tick();
        checks++;
        if (ValidM !== 1'b0 || ReadyE !== 1'b1 || ALUResultM !== '0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ValidM=%b ReadyE=%b ALU=%h RW=%b MW=%b, expected 0 1 0 0 0",
                     ValidM, ReadyE, ALUResultM, RegWriteM, MemWriteM);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        ReadyM = 1'b1;
        ValidE = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_payload(DW'(i));
            tick();
            checks++;
            if (ValidM !== 1'b1 || ALUResultM !== DW'(i) || ReadyE !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d: ValidM=%b ALU=%h ReadyE=%b, expected 1 %h 1", i, ValidM, ALUResultM, ReadyE, i);
            end
        end
        ValidE = 1'b0;
        tick();
        checks++;
        if (ValidM !== 1'b0) begin
            failures++;
            $display("FAIL stream_empty: ValidM=%b, expected 0", ValidM);
        end
    endtask

    task automatic test_backpressure();
        ReadyM = 1'b0;
        ValidE = 1'b1;
        set_payload(32'hA);
        tick();
        set_payload(32'hB);
        tick();
        checks++;
        if (ReadyE !== 1'b0 || ValidM !== 1'b1 || ALUResultM !== 32'hA) begin
            failures++;
            $display("FAIL bp_skid: ReadyE=%b ValidM=%b ALU=%h, expected 0 1 a", ReadyE, ValidM, ALUResultM);
        end
        set_payload(32'hC);
        tick();
        checks++;
        if (ReadyE !== 1'b0 || ALUResultM !== 32'hA) begin
            failures++;
            $display("FAIL bp_hold: ReadyE=%b ALU=%h, expected 0 a", ReadyE, ALUResultM);
        end
        ValidE = 1'b0;
        ReadyM = 1'b1;
        tick();
        checks++;
        if (ValidM !== 1'b1 || ALUResultM !== 32'hB || ReadyE !== 1'b1) begin
            failures++;
            $display("FAIL bp_second: ValidM=%b ALU=%h ReadyE=%b, expected 1 b 1", ValidM, ALUResultM, ReadyE);
        end
        tick();
        checks++;
        if (ValidM !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained: ValidM=%b, expected 0", ValidM);
        end
    endtask

    task automatic test_flush_collision();
        ReadyM = 1'b0;
        ValidE = 1'b1;
        set_payload(32'h10); RegWriteE = 1'b1; MemWriteE = 1'b1;
        tick();
        set_payload(32'h11); RegWriteE = 1'b1; MemWriteE = 1'b1;
        tick();
        checks++;
        if (ReadyE !== 1'b0 || RegWriteM !== 1'b1 || MemWriteM !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: ReadyE=%b RW=%b MW=%b, expected 0 1 1", ReadyE, RegWriteM, MemWriteM);
        end
        flush = 1'b1;
        set_payload(32'h12); RegWriteE = 1'b1; MemWriteE = 1'b1;
        tick();
        checks++;
        if (ValidM !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ReadyE !== 1'b1) begin
            failures++;
            $display("FAIL flush_both: ValidM=%b RW=%b MW=%b ReadyE=%b, expected 0 0 0 1",
                     ValidM, RegWriteM, MemWriteM, ReadyE);
        end
        // Flush while ReadyE is high: the offered entry must be dropped too
        flush = 1'b1;
        set_payload(32'h13);
        tick();
        flush = 1'b0;
        ValidE = 1'b0;
        tick();
        checks++;
        if (ValidM !== 1'b0 || ReadyE !== 1'b1) begin
            failures++;
            $display("FAIL flush_accept: ValidM=%b ReadyE=%b, expected 0 1", ValidM, ReadyE);
        end
    endtask

    task automatic test_reset_mid_stall();
        ReadyM = 1'b0;
        ValidE = 1'b1;
        set_payload(32'h20);
        tick();
        set_payload(32'h21);
        tick();
        ValidE = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ValidM !== 1'b0 || ALUResultM !== '0 || ReadyE !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall: ValidM=%b ALU=%h ReadyE=%b, expected 0 0 1", ValidM, ALUResultM, ReadyE);
        end
        ReadyM = 1'b1;
        ValidE = 1'b1;
        set_payload(32'h5);
        tick();
        ValidE = 1'b0;
        checks++;
        if (ValidM !== 1'b1 || ALUResultM !== 32'h5) begin
            failures++;
            $display("FAIL rst_restart: ValidM=%b ALU=%h, expected 1 5", ValidM, ALUResultM);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic stalled;
        for (int c = 0; c < 400; c++) begin
            ValidE = 1'($urandom_range(0, 3) != 0);
            ReadyM = 1'($urandom_range(0, 2) != 0);
            flush  = 1'($urandom_range(0, 40) == 0);
            set_payload($urandom);
            stalled  = ValidM && !ReadyM && !flush;
            held_vec = out_vec;
            tick();
            if (stalled) begin
                checks++;
                if (ValidM !== 1'b1 || out_vec !== held_vec) begin
                    failures++;
                    $display("FAIL stall_stable: ValidM=%b out=%h, expected 1 %h", ValidM, out_vec, held_vec);
                end
            end
            if (!ValidM) begin
                checks++;
                if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
                    failures++;
                    $display("FAIL bubble_ctrl: RW=%b MW=%b, expected 0 0", RegWriteM, MemWriteM);
                end
            end
        end
        flush  = 1'b0;
        ValidE = 1'b0;
        ReadyM = 1'b1;
        for (int c = 0; c < 5 && ValidM; c++) tick();
        checks++;
        if (ValidM !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain: ValidM=%b pending=%0d, expected 0 0", ValidM, sb.size());
        end
    endtask

`ifdef EX_MEM_STAGE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ReadyM = 1'b0;
        ValidE = 1'b1;
        set_payload(32'h30);
        tick();
        ValidE = 1'b0;
        repeat (10) tick();
        ReadyM = 1'b1;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (StallCount !== 32'd10 || FlushCount !== 16'd1) begin
            failures++;
            $display("FAIL perf_counts: Stall=%0d Flush=%0d, expected 10 1", StallCount, FlushCount);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (FlushCount !== 16'd1) begin
            failures++;
            $display("FAIL perf_empty_flush: Flush=%0d, expected 1", FlushCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_collision();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef EX_MEM_STAGE_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
